seg7_scan_display: RTL and testbench

- Downstream consumer of the data path's 16-bit `final_res` (the register selected by `reg_addr`).
- Shows the value as 4 hex digits on the board's multiplexed, common-anode 7-segment display.
- Scans one digit per refresh slot, latches the value once per frame so digits cannot tear, and blanks anodes briefly at each digit change to stop ghosting.
- Runs on the undivided board clock, in parallel with the data path's divided core clock.

---
 rtl/seg7_scan_display.sv | 134 +++++++++++++
 tb/tb_seg7_scan_display.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Scans a 16-bit word as 4 hex digits onto a common-anode 7-segment display.
// Outputs registered one cycle behind the scan state. Free-running: it takes no flow control.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   latch_q, latch_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          in_guard;
  logic [3:0]    nib;
  logic          lead_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt_q == DIV_LAST);

  // Anodes stay dark for the first GUARD cycles of each slot to suppress ghosting.
  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    assign in_guard = (div_cnt_q < GUARD_C);
  end

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
    digit_d   = tick ? digit_q + 2'd1 : digit_q;
    latch_d   = (tick && (digit_q == 2'd3)) ? value : latch_q;
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    nib        = latch_q[3:0];
    lead_blank = 1'b0;
    case (digit_q)
      2'd0: begin
        nib        = latch_q[3:0];
        lead_blank = 1'b0;
      end
      2'd1: begin
        nib        = latch_q[7:4];
        lead_blank = blank_lz && (latch_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib        = latch_q[11:8];
        lead_blank = blank_lz && (latch_q[15:8] == 8'h00);
      end
      2'd3: begin
        nib        = latch_q[15:12];
        lead_blank = blank_lz && (latch_q[15:12] == 4'h0);
      end
      default: begin
        nib        = latch_q[3:0];
        lead_blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!in_guard) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = lead_blank ? 7'h7F : hex_to_seg(nib);
      dp_d  = ~dp_mask[digit_q];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      div_cnt_q <= '0;
      digit_q   <= 2'd0;
      latch_q   <= 16'h0000;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      digit_q   <= digit_d;
      latch_q   <= latch_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a guarded (GUARD=2) and an unguarded (GUARD=0) instance share all inputs.
module tb_seg7_scan_display;

  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * RD;

  logic        clk_in;
  logic        rst;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an, an_ng;
  logic [6:0]  seg, seg_ng;
  logic        dp, dp_ng;

  int n_pass;
  int n_total;

  seg7_scan_display #(.REFRESH_DIV(RD), .GUARD(GD)) u_dut (
    .clk_in(clk_in), .rst(rst), .value(value), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp)
  );

  seg7_scan_display #(.REFRESH_DIV(RD), .GUARD(0)) u_dut_ng (
    .clk_in(clk_in), .rst(rst), .value(value), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .an(an_ng), .seg(seg_ng), .dp(dp_ng)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: time since reset release gives slot and digit by plain arithmetic.
  logic [6:0]  seg_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_t;
  logic [15:0] m_latch;
  logic [3:0]  exp_an, ng_an;
  logic [6:0]  exp_seg, ng_seg;
  logic        exp_dp, ng_dp;

  always @(posedge clk_in) begin
    int          slot_pos, dig;
    logic [15:0] upper;
    logic [6:0]  s;
    if (!rst) begin
      m_t = 0; m_latch = 16'h0000;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      ng_an  = 4'hF; ng_seg  = 7'h7F; ng_dp  = 1'b1;
    end else begin
      slot_pos = m_t % RD;
      dig      = (m_t / RD) % 4;
      upper    = m_latch >> (4 * dig);
      s        = (blank_lz && dig != 0 && upper == 16'h0) ? 7'h7F : seg_tbl[upper[3:0]];
      ng_an  = ~(4'b0001 << dig);
      ng_seg = s;
      ng_dp  = ~dp_mask[dig];
      if (slot_pos < GD) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an = ng_an; exp_seg = ng_seg; exp_dp = ng_dp;
      end
      if (m_t % FR == FR - 1) m_latch = value;
      m_t = m_t + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b0; value = 16'h1234; blank_lz = 1'b0; dp_mask = 4'h0;
    repeat (3) begin
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1})
        $display("FAIL reset: got %h/%h/%b ng %h/%h/%b want F/7f/1", an, seg, dp, an_ng, seg_ng, dp_ng);
      else n_pass++;
    end
    rst = 1'b1;
  endtask

  task automatic test_scan();
    logic [10:0] want;
    bit          chk;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp})
        $display("FAIL scan_model k=%0d: got %h/%h/%b ng %h/%h/%b want %h/%h/%b ng %h/%h/%b", k,
                 an, seg, dp, an_ng, seg_ng, dp_ng, exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp);
      else n_pass++;
      chk = 1'b1;
      case (k)
        0, 1, 32, 33: want = {4'hF, 7'h7F};
        2:            want = {4'b1110, 7'h40};
        10:           want = {4'b1101, 7'h40};
        26:           want = {4'b0111, 7'h40};
        34:           want = {4'b1110, 7'h19};
        42:           want = {4'b1101, 7'h30};
        50:           want = {4'b1011, 7'h24};
        58:           want = {4'b0111, 7'h79};
        default:      chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if ({an, seg} !== want)
          $display("FAIL scan_fixed k=%0d: got an=%b seg=%h want an=%b seg=%h", k, an, seg, want[10:7], want[6:0]);
        else n_pass++;
      end
      if (k == 0) begin
        n_total++;
        if ({an_ng, seg_ng} !== {4'b1110, 7'h40})
          $display("FAIL scan_noguard_first: got an=%b seg=%h want an=1110 seg=40", an_ng, seg_ng);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] want;
    value = 16'h00A5; blank_lz = 1'b1;
    for (int k = 0; k < 34 + 32 + 2 + 32; k++) begin
      if (k == 34 + 32) blank_lz = 1'b0;
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp})
        $display("FAIL blank_model k=%0d: got %h/%h/%b ng %h/%h/%b want %h/%h/%b ng %h/%h/%b", k,
                 an, seg, dp, an_ng, seg_ng, dp_ng, exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp);
      else n_pass++;
      if ((k >= 34 && k < 66) || k >= 68) begin
        case (an)
          4'b1110: want = 7'h12;
          4'b1101: want = 7'h08;
          4'b1011, 4'b0111: want = (k < 66) ? 7'h7F : 7'h40;
          default: want = 7'h7F;
        endcase
        n_total++;
        if (seg !== want)
          $display("FAIL blank_lz k=%0d an=%b: got seg=%h want %h", k, an, seg, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero();
    logic [6:0] want;
    value = 16'h0000; blank_lz = 1'b1;
    for (int k = 0; k < 34 + 32; k++) begin
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp})
        $display("FAIL zero_model k=%0d: got %h/%h/%b ng %h/%h/%b want %h/%h/%b ng %h/%h/%b", k,
                 an, seg, dp, an_ng, seg_ng, dp_ng, exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp);
      else n_pass++;
      if (k >= 34) begin
        want = (an == 4'b1110) ? 7'h40 : 7'h7F;
        n_total++;
        if (seg !== want)
          $display("FAIL zero_blank k=%0d an=%b: got seg=%h want %h", k, an, seg, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame_latch();
    int         w;
    logic [6:0] want;
    value = 16'h1111; blank_lz = 1'b0;
    repeat (34) @(negedge clk_in);
    w = 0;
    while (an !== 4'b1101 && w < 40) begin @(negedge clk_in); w++; end
    n_total++;
    if (an !== 4'b1101) $display("FAIL latch_wait_digit1: got an=%b want 1101", an);
    else n_pass++;
    value = 16'hFFFF;
    w = 0;
    do begin
      @(negedge clk_in); w++;
      n_total++;
      if (an != 4'hF && seg !== 7'h79)
        $display("FAIL latch_hold an=%b: got seg=%h want 79", an, seg);
      else n_pass++;
    end while (m_t % FR != 0 && w < 40);
    for (int k = 0; k < FR; k++) begin
      @(negedge clk_in);
      want = (an == 4'hF) ? 7'h7F : 7'h0E;
      n_total++;
      if (seg !== want || {an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL latch_next_frame k=%0d an=%b: got seg=%h want %h (model %h)", k, an, seg, want, exp_seg);
      else n_pass++;
    end
    // Bracket the frame-end sampling cycle with different values.
    w = 0;
    while (m_t % FR != FR - 2 && w < 40) begin @(negedge clk_in); w++; end
    value = 16'h5555;
    @(negedge clk_in);
    value = 16'hABCD;
    @(negedge clk_in);
    value = 16'h0000;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk_in);
      case (an)
        4'b1110: want = 7'h21;
        4'b1101: want = 7'h46;
        4'b1011: want = 7'h03;
        4'b0111: want = 7'h08;
        default: want = 7'h7F;
      endcase
      n_total++;
      if (seg !== want || {an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL latch_exact k=%0d an=%b: got seg=%h want %h", k, an, seg, want);
      else n_pass++;
    end
  endtask

  task automatic test_dp();
    logic want, want_ng;
    value = 16'h1234; blank_lz = 1'b0; dp_mask = 4'b0100;
    for (int k = 0; k < 2 + 2 * FR; k++) begin
      @(negedge clk_in);
      if (k >= 2) begin
        want    = (an == 4'b1011) ? 1'b0 : 1'b1;
        want_ng = (an_ng == 4'b1011) ? 1'b0 : 1'b1;
        n_total++;
        if (dp !== want || dp_ng !== want_ng || dp !== exp_dp)
          $display("FAIL dp_mask k=%0d an=%b: got dp=%b ng=%b want %b ng=%b", k, an, dp, dp_ng, want, want_ng);
        else n_pass++;
      end
    end
    dp_mask = 4'h0;
  endtask

  task automatic test_reset_mid();
    int          w;
    logic [10:0] want;
    bit          chk;
    w = 0;
    while (m_t % FR != 2 * RD + 3 && w < 40) begin @(negedge clk_in); w++; end
    n_total++;
    if (an !== 4'b1011) $display("FAIL rstmid_slot: got an=%b want 1011", an);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk_in);
    n_total++;
    if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {4'hF, 7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1})
      $display("FAIL rstmid_outputs: got %h/%h/%b ng %h/%h/%b want F/7f/1", an, seg, dp, an_ng, seg_ng, dp_ng);
    else n_pass++;
    rst = 1'b1;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp})
        $display("FAIL rstmid_model k=%0d: got %h/%h/%b ng %h/%h/%b want %h/%h/%b ng %h/%h/%b", k,
                 an, seg, dp, an_ng, seg_ng, dp_ng, exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp);
      else n_pass++;
      n_total++;
      if (an_ng === 4'hF) $display("FAIL rstmid_noguard_dark k=%0d: got an=%b want not 1111", k, an_ng);
      else n_pass++;
      chk = 1'b1;
      case (k)
        0, 1, 8, 9: want = {4'hF, 7'h7F};
        2:          want = {4'b1110, 7'h40};
        10:         want = {4'b1101, 7'h40};
        33:         want = {4'hF, 7'h7F};
        default:    chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if ({an, seg} !== want)
          $display("FAIL rstmid_restart k=%0d: got an=%b seg=%h want an=%b seg=%h", k, an, seg, want[10:7], want[6:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [0:4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int k = 0; k < 12 * FR; k++) begin
      value    = 16'($urandom) & masks[$urandom_range(0, 4)];
      blank_lz = 1'($urandom);
      dp_mask  = 4'($urandom);
      rst      = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      @(negedge clk_in);
      n_total++;
      if ({an, seg, dp, an_ng, seg_ng, dp_ng} !== {exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp})
        $display("FAIL random_model k=%0d: got %h/%h/%b ng %h/%h/%b want %h/%h/%b ng %h/%h/%b", k,
                 an, seg, dp, an_ng, seg_ng, dp_ng, exp_an, exp_seg, exp_dp, ng_an, ng_seg, ng_dp);
      else n_pass++;
    end
    rst = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; value = 16'h0; blank_lz = 1'b0; dp_mask = 4'h0;
    test_reset();
    test_scan();
    test_blank_lz();
    test_zero();
    test_frame_latch();
    test_dp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
